// File: rtl/mem_arbiter_ctrl.sv
// Byte-serial arbiter sharing one 8-bit RAM port between instruction fetch and the MEM stage.
// MEM wins ties; a redirect (pcJump) abandons an in-flight fetch without a done pulse.
module mem_arbiter_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  pcJump_in,
  input  logic                  if_req_in,
  input  logic [31:0]           if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_inst_out,
  input  logic                  mem_req_in,
  input  logic                  mem_we_in,
  input  logic [1:0]            mem_size_in,
  input  logic [31:0]           mem_addr_in,
  input  logic [31:0]           mem_wdata_in,
  output logic                  mem_done_out,
  output logic [31:0]           mem_rdata_out,
  output logic [RAM_ADDR_W-1:0] ram_addr_out,
  output logic                  ram_wr_out,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic                  stallIF_out,
  output logic                  stallMEM_out
);

  typedef enum logic [1:0] {S_IDLE, S_IF_RD, S_MEM_RD, S_MEM_WR} state_t;

  state_t                r_state, w_next;
  logic [2:0]            r_cnt, r_n;
  logic [RAM_ADDR_W-1:0] r_addr;
  logic [31:0]           r_wdata, r_buf, r_inst, r_rdata, w_asm;
  logic [1:0]            w_bidx;
  logic                  w_xfer, w_last;
  logic                  w_start_if, w_start_mem, w_if_done, w_mem_done, w_rd_done;
  logic                  w_unused;

  // Upper request-address bits are deliberately dropped: the RAM space wraps.
  assign w_unused = ^{if_addr_in[31:RAM_ADDR_W], mem_addr_in[31:RAM_ADDR_W]};

  function automatic logic [2:0] f_nbytes(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign w_xfer = (r_cnt < r_n);
  assign w_last = (r_cnt == r_n);
  // Byte captured this cycle belongs to the address driven one cycle earlier.
  assign w_bidx = 2'(r_cnt - 3'd1);

  always_comb begin
    w_next      = r_state;
    w_start_if  = 1'b0;
    w_start_mem = 1'b0;
    w_if_done   = 1'b0;
    w_mem_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req_in) begin
          w_start_mem = 1'b1;
          w_next      = mem_we_in ? S_MEM_WR : S_MEM_RD;
        end else if (if_req_in && !pcJump_in) begin
          w_start_if = 1'b1;
          w_next     = S_IF_RD;
        end
      end
      S_IF_RD: begin
        if (!if_req_in || pcJump_in) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_if_done = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_MEM_RD, S_MEM_WR: begin
        if (!mem_req_in) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_mem_done = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rd_done = w_mem_done && (r_state == S_MEM_RD);

  // Final byte arrives on the done cycle, so the result is merged combinationally.
  always_comb begin
    w_asm = r_buf;
    w_asm[{w_bidx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
      r_inst  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_mem) begin
        r_cnt   <= '0;
        r_n     <= f_nbytes(mem_size_in);
        r_addr  <= mem_addr_in[RAM_ADDR_W-1:0];
        r_wdata <= mem_wdata_in;
        r_buf   <= '0;
      end else if (w_start_if) begin
        r_cnt   <= '0;
        r_n     <= 3'd4;
        r_addr  <= if_addr_in[RAM_ADDR_W-1:0];
        r_wdata <= '0;
        r_buf   <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt != 3'd0 && r_state != S_MEM_WR)
          r_buf[{w_bidx, 3'b000} +: 8] <= ram_din;
      end
      if (w_if_done) r_inst  <= w_asm;
      if (w_rd_done) r_rdata <= w_asm;
    end
  end

  always_comb begin
    ram_addr_out = '0;
    ram_wr_out   = 1'b0;
    ram_dout     = '0;
    if (r_state != S_IDLE && w_xfer) begin
      ram_addr_out = r_addr + RAM_ADDR_W'(r_cnt);
      if (r_state == S_MEM_WR) begin
        ram_wr_out = 1'b1;
        ram_dout   = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
      end
    end
  end

  assign if_done_out   = w_if_done;
  assign if_inst_out   = w_if_done ? w_asm : r_inst;
  assign mem_done_out  = w_mem_done;
  assign mem_rdata_out = w_rd_done ? w_asm : r_rdata;
  assign stallIF_out   = if_req_in && !if_done_out;
  assign stallMEM_out  = mem_req_in && !mem_done_out;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: byte RAM model, shadow memory reference, vector table,
// hand sequences for arbitration/redirect/reset, and a randomized transaction run.
module tb_mem_arbiter_ctrl;
  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;

  logic          clk_in = 1'b0;
  logic          rst_in, pcJump_in, if_req_in, mem_req_in, mem_we_in;
  logic [31:0]   if_addr_in, mem_addr_in, mem_wdata_in;
  logic [1:0]    mem_size_in;
  logic          if_done_out, mem_done_out, ram_wr_out, stallIF_out, stallMEM_out;
  logic [31:0]   if_inst_out, mem_rdata_out;
  logic [AW-1:0] ram_addr_out;
  logic [7:0]    ram_dout, ram_din;

  logic [7:0] ram    [MSZ];
  logic [7:0] shadow [MSZ];
  int n_cmp = 0, n_bad = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pcJump_in(pcJump_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_done_out(if_done_out), .if_inst_out(if_inst_out),
    .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_size_in(mem_size_in), .mem_addr_in(mem_addr_in),
    .mem_wdata_in(mem_wdata_in), .mem_done_out(mem_done_out), .mem_rdata_out(mem_rdata_out),
    .ram_addr_out(ram_addr_out), .ram_wr_out(ram_wr_out), .ram_dout(ram_dout), .ram_din(ram_din),
    .stallIF_out(stallIF_out), .stallMEM_out(stallMEM_out)
  );

  // Synchronous-read byte RAM
  always @(posedge clk_in) begin
    ram_din <= ram[ram_addr_out];
    if (ram_wr_out) ram[ram_addr_out] = ram_dout;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input bit is_mem, input bit [1:0] sz);
    if (!is_mem) return 4;
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = shadow[AW'(addr + 32'(k))];
    return v;
  endfunction

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    ram[a] = d;
    shadow[a] = d;
  endtask

  // One request from an idle arbiter; lat counts cycles from the accepting IDLE cycle.
  task automatic do_txn(input bit is_mem, input bit we, input bit [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] got, output int lat);
    int n = nbytes(is_mem, sz);
    bit seen = 0, stall_ok = 1, wr_ok = 1;
    logic [AW-1:0] a;
    got = '0;
    lat = -1;
    if (is_mem) begin
      mem_req_in = 1; mem_we_in = we; mem_size_in = sz; mem_addr_in = addr; mem_wdata_in = wd;
    end else begin
      if_req_in = 1; if_addr_in = addr;
    end
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_in);
      if (is_mem ? mem_done_out : if_done_out) begin
        seen = 1;
        lat  = c;
        got  = is_mem ? mem_rdata_out : if_inst_out;
        if (ram_wr_out) wr_ok = 0;
        if (is_mem ? stallMEM_out : stallIF_out) stall_ok = 0;
      end else if (!(is_mem ? stallMEM_out : stallIF_out)) stall_ok = 0;
      @(posedge clk_in); #1;
    end
    mem_req_in = 0; if_req_in = 0; mem_we_in = 0;
    chk("stall_profile", 32'(stall_ok), 32'd1);
    if (is_mem && we) begin
      chk("wr_low_at_done", 32'(wr_ok), 32'd1);
      for (int k = 0; k < n; k++) begin
        a = AW'(addr + 32'(k));
        shadow[a] = wd[8*k +: 8];
        chk("store_byte", 32'(ram[a]), 32'(shadow[a]));
      end
    end
  endtask

  typedef struct {
    string       name;
    bit          is_mem;
    bit          we;
    bit [1:0]    sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] got, inst, mrd, exp_v, prev_inst, zacc;
  logic [AW-1:0] a_idle;
  int          lat, md, idn;
  bit          s_if, hold_ok, r_mem, r_we;
  bit [1:0]    r_sz;
  logic [31:0] r_addr, r_wd;

  initial begin
    tbl[0] = '{"if_word_0",      0, 0, 2'b10, 32'h0000_0000, 32'h0,          32'h0010_0513, 5};
    tbl[1] = '{"ld_half_102",    1, 0, 2'b01, 32'h0000_0102, 32'h0,          32'h0000_FF80, 3};
    tbl[2] = '{"st_word_200",    1, 1, 2'b10, 32'h0000_0200, 32'hDEAD_BEEF,  32'h0,         5};
    tbl[3] = '{"ld_word_200",    1, 0, 2'b10, 32'h0000_0200, 32'h0,          32'hDEAD_BEEF, 5};
    tbl[4] = '{"ld_byte_hiaddr", 1, 0, 2'b00, 32'hFFFE_0103, 32'h0,          32'h0000_00FF, 2};
    tbl[5] = '{"st_half_wrap",   1, 1, 2'b01, 32'h0001_FFFF, 32'h1234_5678,  32'h0,         3};
    tbl[6] = '{"if_wrap",        0, 0, 2'b10, 32'h0001_FFFE, 32'h0,          32'h0556_78AA, 5};
    tbl[7] = '{"ld_size11",      1, 0, 2'b11, 32'h0000_0000, 32'h0,          32'h0010_0556, 5};

    for (int i = 0; i < MSZ; i++) begin
      ram[i]    = 8'($urandom);
      shadow[i] = ram[i];
    end
    poke(17'h0, 8'h13); poke(17'h1, 8'h05); poke(17'h2, 8'h10); poke(17'h3, 8'h00);
    poke(17'h102, 8'h80); poke(17'h103, 8'hFF); poke(17'h1FFFE, 8'hAA);
    poke(17'h40, 8'h93); poke(17'h41, 8'h02); poke(17'h42, 8'h30); poke(17'h43, 8'h00);

    rst_in = 1; pcJump_in = 0; if_req_in = 0; mem_req_in = 0; mem_we_in = 0;
    mem_size_in = 0; if_addr_in = 0; mem_addr_in = 0; mem_wdata_in = 0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 0;
    @(negedge clk_in);
    chk("rst_if_done",  32'(if_done_out), 0);
    chk("rst_mem_done", 32'(mem_done_out), 0);
    chk("rst_inst",     if_inst_out, 0);
    chk("rst_rdata",    mem_rdata_out, 0);
    chk("rst_ram_bus",  {ram_wr_out, ram_dout, 6'b0, ram_addr_out}, 0);
    @(posedge clk_in); #1;

    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].is_mem, tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd, got, lat);
      chk({tbl[i].name, "_lat"}, 32'(lat), 32'(tbl[i].lat));
      if (!tbl[i].we) chk({tbl[i].name, "_data"}, got, tbl[i].exp);
    end

    // Simultaneous IF and MEM: MEM half-load first, IF accepted the cycle after mem_done.
    mem_req_in = 1; mem_we_in = 0; mem_size_in = 2'b01; mem_addr_in = 32'h102;
    if_req_in = 1; if_addr_in = 32'h0;
    md = -1; idn = -1; s_if = 0;
    for (int c = 0; c < 30 && idn < 0; c++) begin
      @(negedge clk_in);
      if (mem_done_out) begin md = c; mrd = mem_rdata_out; s_if = stallIF_out; end
      if (if_done_out) begin idn = c; inst = if_inst_out; end
      @(posedge clk_in); #1;
      if (md >= 0) mem_req_in = 0;
    end
    if_req_in = 0;
    chk("tie_mem_done_cyc", 32'(md), 32'd3);
    chk("tie_mem_data",     mrd, 32'h0000_FF80);
    chk("tie_stallIF_wait", 32'(s_if), 32'd1);
    chk("tie_if_done_cyc",  32'(idn), 32'd9);
    chk("tie_if_data",      inst, model_load(32'h0, 4));
    prev_inst = model_load(32'h0, 4);

    // Redirect on IF transfer cycle 2; refetch at 0x40 accepted in the following IDLE cycle.
    if_req_in = 1; if_addr_in = 32'h80;
    idn = -1; hold_ok = 1; a_idle = '1;
    for (int c = 0; c < 30 && idn < 0; c++) begin
      pcJump_in = (c == 3);
      if (c == 3) if_addr_in = 32'h40;
      @(negedge clk_in);
      if (if_done_out) begin idn = c; inst = if_inst_out; end
      else if (if_inst_out !== prev_inst) hold_ok = 0;
      if (c == 4) a_idle = ram_addr_out;
      @(posedge clk_in); #1;
    end
    pcJump_in = 0; if_req_in = 0;
    chk("jump_idle_addr", 32'(a_idle), 32'd0);
    chk("jump_inst_hold", 32'(hold_ok), 32'd1);
    chk("jump_refetch_cyc", 32'(idn), 32'd9);
    chk("jump_refetch_data", inst, 32'h0030_0293);

    // Redirect while idle blocks the IF start for that cycle only.
    if_req_in = 1; if_addr_in = 32'h40; idn = -1;
    for (int c = 0; c < 30 && idn < 0; c++) begin
      pcJump_in = (c == 0);
      @(negedge clk_in);
      if (if_done_out) idn = c;
      @(posedge clk_in); #1;
    end
    pcJump_in = 0; if_req_in = 0;
    chk("jump_idle_block_cyc", 32'(idn), 32'd6);

    // Reset during store transfer cycle 1.
    mem_req_in = 1; mem_we_in = 1; mem_size_in = 2'b10; mem_addr_in = 32'h300; mem_wdata_in = 32'hCAFE_F00D;
    zacc = '0; md = -1;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin rst_in = 1; mem_req_in = 0; mem_we_in = 0; end
      if (c == 3) rst_in = 0;
      @(negedge clk_in);
      if (mem_done_out) md = c;
      if (c >= 3) zacc = zacc | mem_rdata_out | if_inst_out |
                         {ram_wr_out, ram_dout, mem_done_out, if_done_out, 5'b0, ram_addr_out};
      @(posedge clk_in); #1;
    end
    shadow[17'h300] = 8'h0D; shadow[17'h301] = 8'hF0;
    chk("rst_mid_outputs_zero", zacc, 32'd0);
    chk("rst_mid_no_done", 32'(md), 32'hFFFF_FFFF);
    chk("rst_mid_byte0", 32'(ram[17'h300]), 32'(shadow[17'h300]));
    chk("rst_mid_byte1", 32'(ram[17'h301]), 32'(shadow[17'h301]));
    chk("rst_mid_byte2", 32'(ram[17'h302]), 32'(shadow[17'h302]));
    chk("rst_mid_byte3", 32'(ram[17'h303]), 32'(shadow[17'h303]));

    // Randomized transactions checked against the shadow memory.
    for (int t = 0; t < 60; t++) begin
      r_mem  = ($urandom_range(0, 2) != 0);
      r_we   = r_mem && ($urandom_range(0, 1) == 1);
      r_sz   = 2'($urandom_range(0, 3));
      r_addr = $urandom;
      if ($urandom_range(0, 3) == 0) r_addr[16:0] = 17'h1FFFC + 17'($urandom_range(0, 5));
      r_wd   = $urandom;
      exp_v  = model_load(r_addr, nbytes(r_mem, r_sz));
      do_txn(r_mem, r_we, r_sz, r_addr, r_wd, got, lat);
      chk("rnd_lat", 32'(lat), 32'(nbytes(r_mem, r_sz) + 1));
      if (!r_we) chk("rnd_data", got, exp_v);
      repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
